ofs_fim_pcie_ss_tx_arb: RTL and testbench

Packet-atomic round-robin arbiter that merges up to four FPGA-to-host AXI-S TLP streams onto the single PCIe SS TX stream. It sits between the FIM TX producers (MMIO completion path, AFU/host channel, FME) and the PCIe SS TX port. A granted TLP is never interleaved with another source. The merged stream leaves through one registered output stage.

---
 rtl/ofs_fim_pcie_ss_tx_arb_pkg.sv | 43 ++++
 rtl/pcie_ss_axis_if.sv | 22 ++
 rtl/ofs_fim_pcie_ss_rr_pick.sv | 21 ++
 rtl/ofs_fim_pcie_ss_tx_arb.sv | 147 ++++++++++++++
 tb/tb_ofs_fim_pcie_ss_tx_arb.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_fim_pcie_ss_tx_arb_pkg.sv
// Shared types and the rotating-priority pick used by the FIM TX arbiters.
package ofs_fim_pcie_ss_tx_arb_pkg;

    localparam int unsigned MAX_SRC = 4;

    typedef logic [1:0] t_src_idx;

    typedef enum logic [0:0] {
        StOpen,
        StLocked
    } t_arb_state;

    typedef struct packed {
        logic     found;
        t_src_idx idx;
    } t_rr_pick;

    // First set bit of valid at or after ptr, wrapping within num_src entries.
    function automatic t_rr_pick rr_pick(
        input logic [MAX_SRC-1:0] valid,
        input t_src_idx           ptr,
        input int unsigned        num_src
    );
        t_rr_pick    pick;
        int unsigned j;
        pick = '0;
        j    = 0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            if (k < num_src && !pick.found) begin
                j = 32'(ptr) + k;
                if (j >= num_src) begin
                    j = j - num_src;
                end
                if (valid[j[1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = t_src_idx'(j);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-S TLP stream bundle used between FIM blocks and the PCIe SS.
interface pcie_ss_axis_if #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 10
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser_vendor;

    modport source (
        output tvalid, tdata, tkeep, tlast, tuser_vendor,
        input  tready
    );

    modport sink (
        input  tvalid, tdata, tkeep, tlast, tuser_vendor,
        output tready
    );
endinterface

// File: rtl/ofs_fim_pcie_ss_rr_pick.sv
// Combinational rotating priority encoder shared by FIM arbiters.
module ofs_fim_pcie_ss_rr_pick
    import ofs_fim_pcie_ss_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic [MAX_SRC-1:0] valid,
    input  t_src_idx           ptr,
    output t_src_idx           idx,
    output logic               found
);

    t_rr_pick pick;

    always_comb begin
        pick  = rr_pick(valid, ptr, NUM_SRC);
        idx   = pick.idx;
        found = pick.found;
    end

endmodule

// File: rtl/ofs_fim_pcie_ss_tx_arb.sv
// Packet-atomic round-robin merge of up to four TX TLP streams onto the PCIe SS TX port.
module ofs_fim_pcie_ss_tx_arb
    import ofs_fim_pcie_ss_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned USER_W  = 10
) (
    input  logic           fim_clk,
    input  logic           fim_rst_n,
    pcie_ss_axis_if.sink   src_if [NUM_SRC],
    pcie_ss_axis_if.source tx_if,
    output t_src_idx       active_src,
    output logic           busy
);

    localparam int unsigned KEEP_W   = DATA_W / 8;
    localparam t_src_idx    LAST_IDX = t_src_idx'(NUM_SRC - 1);

    logic [MAX_SRC-1:0] src_valid;
    logic [MAX_SRC-1:0] src_last;
    logic [MAX_SRC-1:0] src_ready;
    logic [DATA_W-1:0]  src_data [MAX_SRC];
    logic [KEEP_W-1:0]  src_keep [MAX_SRC];
    logic [USER_W-1:0]  src_user [MAX_SRC];

    // Flatten the interface array so the candidate can be selected with a variable index.
    for (genvar i = 0; i < MAX_SRC; i++) begin : g_src
        if (i < NUM_SRC) begin : g_used
            assign src_valid[i]     = src_if[i].tvalid;
            assign src_last[i]      = src_if[i].tlast;
            assign src_data[i]      = src_if[i].tdata;
            assign src_keep[i]      = src_if[i].tkeep;
            assign src_user[i]      = src_if[i].tuser_vendor;
            assign src_if[i].tready = src_ready[i];
        end else begin : g_pad
            assign src_valid[i] = 1'b0;
            assign src_last[i]  = 1'b0;
            assign src_data[i]  = '0;
            assign src_keep[i]  = '0;
            assign src_user[i]  = '0;
        end
    end

    t_arb_state        state_q, state_d;
    t_src_idx          grant_idx_q, grant_idx_d;
    t_src_idx          rr_ptr_q, rr_ptr_d;
    t_src_idx          last_idx_q, last_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [KEEP_W-1:0] out_keep_q, out_keep_d;
    logic [USER_W-1:0] out_user_q, out_user_d;

    t_src_idx pick_idx;
    logic     pick_found;
    t_src_idx cand;
    logic     cand_valid;
    logic     load;
    logic     accept;

    ofs_fim_pcie_ss_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .valid (src_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // While locked only the granted source is considered, whatever the others present.
    assign cand       = (state_q == StLocked) ? grant_idx_q : pick_idx;
    assign cand_valid = (state_q == StLocked) ? src_valid[cand] : pick_found;
    assign load       = !out_valid_q || tx_if.tready;
    assign accept     = cand_valid && load;

    always_comb begin
        src_ready = '0;
        if (fim_rst_n && load && (state_q == StLocked || pick_found)) begin
            src_ready[cand] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        last_idx_d  = last_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = src_last[cand];
            out_data_d  = src_data[cand];
            out_keep_d  = src_keep[cand];
            out_user_d  = src_user[cand];
            last_idx_d  = cand;
            if (src_last[cand]) begin
                state_d  = StOpen;
                rr_ptr_d = (cand == LAST_IDX) ? t_src_idx'(0) : cand + t_src_idx'(1);
            end else begin
                state_d     = StLocked;
                grant_idx_d = cand;
            end
        end else if (tx_if.tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            state_q     <= StOpen;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            last_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            last_idx_q  <= last_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
        end
    end

    assign tx_if.tvalid       = out_valid_q;
    assign tx_if.tlast        = out_last_q;
    assign tx_if.tdata        = out_data_q;
    assign tx_if.tkeep        = out_keep_q;
    assign tx_if.tuser_vendor = out_user_q;

    assign busy       = (state_q == StLocked);
    assign active_src = (state_q == StLocked) ? grant_idx_q : last_idx_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_arb.sv
// Directed checks of the packet-atomic TX arbiter with two sources.
module tb_ofs_fim_pcie_ss_tx_arb;
    import ofs_fim_pcie_ss_tx_arb_pkg::*;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned USER_W  = 8;

    logic     fim_clk = 1'b0;
    logic     fim_rst_n;
    t_src_idx active_src;
    logic     busy;
    int       nvec;
    int       nmis;

    pcie_ss_axis_if #(.DATA_W(DATA_W), .USER_W(USER_W)) src_if [NUM_SRC] ();
    pcie_ss_axis_if #(.DATA_W(DATA_W), .USER_W(USER_W)) tx_if ();

    ofs_fim_pcie_ss_tx_arb #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .USER_W  (USER_W)
    ) dut (
        .fim_clk    (fim_clk),
        .fim_rst_n  (fim_rst_n),
        .src_if     (src_if),
        .tx_if      (tx_if),
        .active_src (active_src),
        .busy       (busy)
    );

    always #5 fim_clk = ~fim_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src(input int s, input logic v, input logic [31:0] d, input logic l);
        case (s)
            0: begin
                src_if[0].tvalid       = v;
                src_if[0].tdata        = d;
                src_if[0].tkeep        = '1;
                src_if[0].tlast        = l;
                src_if[0].tuser_vendor = d[7:0];
            end
            default: begin
                src_if[1].tvalid       = v;
                src_if[1].tdata        = d;
                src_if[1].tkeep        = '1;
                src_if[1].tlast        = l;
                src_if[1].tuser_vendor = d[7:0];
            end
        endcase
    endtask

    task automatic step();
        @(posedge fim_clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic l,
                               input logic [1:0] src, input logic bsy);
        check({tag, "_tvalid"}, tx_if.tvalid, 1'b1);
        check({tag, "_tdata"}, tx_if.tdata, d);
        check({tag, "_tlast"}, tx_if.tlast, l);
        check({tag, "_tuser"}, tx_if.tuser_vendor, d[7:0]);
        check({tag, "_active"}, active_src, src);
        check({tag, "_busy"}, busy, bsy);
    endtask

    initial begin
        nvec      = 0;
        nmis      = 0;
        fim_rst_n = 1'b0;
        tx_if.tready = 1'b1;
        drive_src(0, 1'b1, 32'h11, 1'b1);
        drive_src(1, 1'b0, 32'h0, 1'b0);
        #2;
        check("rst_rdy0", src_if[0].tready, 1'b0);
        check("rst_tvalid", tx_if.tvalid, 1'b0);
        check("rst_tlast", tx_if.tlast, 1'b0);
        check("rst_tdata", tx_if.tdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_active", active_src, 2'd0);
        step();
        check("rst_hold_tvalid", tx_if.tvalid, 1'b0);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        fim_rst_n = 1'b1;
        step();

        // Single beat from src0
        drive_src(0, 1'b1, 32'hA5, 1'b1);
        #1;
        check("t1_rdy0", src_if[0].tready, 1'b1);
        check("t1_rdy1", src_if[1].tready, 1'b0);
        check("t1_pre_tvalid", tx_if.tvalid, 1'b0);
        step();
        expect_beat("t1", 32'hA5, 1'b1, 2'd0, 1'b0);
        check("t1_tkeep", tx_if.tkeep, 4'hF);
        drive_src(0, 1'b0, 32'h0, 1'b0);

        // Both sources streaming single-beat packets: rr_ptr is 1, so src1 goes first
        drive_src(0, 1'b1, 32'hB0, 1'b1);
        drive_src(1, 1'b1, 32'hB1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) check("t2_rdy1", src_if[1].tready, 1'b1);
            else            check("t2_rdy0", src_if[0].tready, 1'b1);
            step();
            if (k % 2 == 0) expect_beat("t2", 32'hB1, 1'b1, 2'd1, 1'b0);
            else            expect_beat("t2", 32'hB0, 1'b1, 2'd0, 1'b0);
        end
        drive_src(0, 1'b0, 32'h0, 1'b0);
        drive_src(1, 1'b0, 32'h0, 1'b0);
        step();
        check("t2_idle_tvalid", tx_if.tvalid, 1'b0);

        // 4-beat src0 packet with src1 joining at beat 2
        drive_src(0, 1'b1, 32'hC0, 1'b0);
        step();
        expect_beat("t3_b1", 32'hC0, 1'b0, 2'd0, 1'b1);
        drive_src(0, 1'b1, 32'hC1, 1'b0);
        drive_src(1, 1'b1, 32'hD1, 1'b1);
        #1;
        check("t3_rdy1_b2", src_if[1].tready, 1'b0);
        check("t3_rdy0_b2", src_if[0].tready, 1'b1);
        step();
        expect_beat("t3_b2", 32'hC1, 1'b0, 2'd0, 1'b1);
        drive_src(0, 1'b1, 32'hC2, 1'b0);
        step();
        expect_beat("t3_b3", 32'hC2, 1'b0, 2'd0, 1'b1);
        drive_src(0, 1'b1, 32'hC3, 1'b1);
        #1;
        check("t3_rdy1_b4", src_if[1].tready, 1'b0);
        step();
        expect_beat("t3_b4", 32'hC3, 1'b1, 2'd0, 1'b0);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        #1;
        check("t3_rdy1_after", src_if[1].tready, 1'b1);
        step();
        expect_beat("t3_src1", 32'hD1, 1'b1, 2'd1, 1'b0);
        drive_src(1, 1'b0, 32'h0, 1'b0);
        step();
        check("t3_idle_tvalid", tx_if.tvalid, 1'b0);

        // Backpressure for 3 cycles while beat 2 sits in the output register
        drive_src(0, 1'b1, 32'hE0, 1'b0);
        step();
        expect_beat("t4_b1", 32'hE0, 1'b0, 2'd0, 1'b1);
        drive_src(0, 1'b1, 32'hE1, 1'b0);
        step();
        expect_beat("t4_b2", 32'hE1, 1'b0, 2'd0, 1'b1);
        tx_if.tready = 1'b0;
        drive_src(0, 1'b1, 32'hE2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_stall_rdy0", src_if[0].tready, 1'b0);
            step();
            expect_beat("t4_hold", 32'hE1, 1'b0, 2'd0, 1'b1);
        end
        tx_if.tready = 1'b1;
        #1;
        check("t4_resume_rdy0", src_if[0].tready, 1'b1);
        step();
        expect_beat("t4_b3", 32'hE2, 1'b1, 2'd0, 1'b0);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        step();
        check("t4_idle_tvalid", tx_if.tvalid, 1'b0);

        // Locked src0 drops tvalid for 2 cycles while src1 waits
        drive_src(0, 1'b1, 32'hF0, 1'b0);
        step();
        expect_beat("t5_b1", 32'hF0, 1'b0, 2'd0, 1'b1);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        drive_src(1, 1'b1, 32'hD2, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t5_gap_rdy1", src_if[1].tready, 1'b0);
            step();
            check("t5_gap_tvalid", tx_if.tvalid, 1'b0);
            check("t5_gap_busy", busy, 1'b1);
        end
        drive_src(0, 1'b1, 32'hF1, 1'b1);
        #1;
        check("t5_rdy0", src_if[0].tready, 1'b1);
        check("t5_rdy1", src_if[1].tready, 1'b0);
        step();
        expect_beat("t5_b2", 32'hF1, 1'b1, 2'd0, 1'b0);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        #1;
        check("t5_rdy1_after", src_if[1].tready, 1'b1);
        step();
        expect_beat("t5_src1", 32'hD2, 1'b1, 2'd1, 1'b0);
        drive_src(1, 1'b0, 32'h0, 1'b0);
        step();
        check("t5_idle_tvalid", tx_if.tvalid, 1'b0);

        // Reset mid-packet: move rr_ptr to 1 first so its reset value is observable
        drive_src(0, 1'b1, 32'h70, 1'b1);
        step();
        expect_beat("t6_pre", 32'h70, 1'b1, 2'd0, 1'b0);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        drive_src(1, 1'b1, 32'h90, 1'b0);
        step();
        expect_beat("t6_b1", 32'h90, 1'b0, 2'd1, 1'b1);
        drive_src(1, 1'b1, 32'h91, 1'b0);
        step();
        expect_beat("t6_b2", 32'h91, 1'b0, 2'd1, 1'b1);
        drive_src(1, 1'b1, 32'h92, 1'b0);
        fim_rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", tx_if.tvalid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_active", active_src, 2'd0);
        check("t6_rst_rdy1", src_if[1].tready, 1'b0);
        drive_src(1, 1'b0, 32'h0, 1'b0);
        step();
        fim_rst_n = 1'b1;
        drive_src(0, 1'b1, 32'h80, 1'b1);
        drive_src(1, 1'b1, 32'h81, 1'b1);
        #1;
        check("t6_post_rdy0", src_if[0].tready, 1'b1);
        check("t6_post_rdy1", src_if[1].tready, 1'b0);
        step();
        expect_beat("t6_post_src0", 32'h80, 1'b1, 2'd0, 1'b0);
        drive_src(0, 1'b0, 32'h0, 1'b0);
        step();
        expect_beat("t6_post_src1", 32'h81, 1'b1, 2'd1, 1'b0);
        drive_src(1, 1'b0, 32'h0, 1'b0);
        step();
        check("t6_idle_tvalid", tx_if.tvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
